traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Two-way intersection sequencer for the traffic-light model. Contains its own seconds prescaler. Steps the north-south (NS) and east-west (EW) signal heads through green, yellow and all-red phases, each timed in whole seconds. NS green is held until an EW vehicle request is pending. A maintenance input overrides normal sequencing with flashing yellow. A seconds-remaining count is exported for the countdown display path.

## Interface
- TICK_DIV, 60: one second = TICK_DIV+1 clk cycles; legal range ≥1
- GREEN_SEC, 9: green duration in seconds; legal range 1..15
- YELLOW_SEC, 2: yellow duration in seconds; legal range 1..15
- ALLRED_SEC, 1: all-red clearance in seconds; legal range 1..15
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ew_req  input  1  EW vehicle sensor, level, synchronous to clk
- maint  input  1  maintenance/flash mode request, level, synchronous
- ns_light  output  3  {red, yellow, green}, one-hot or 000
- ew_light  output  3  {red, yellow, green}, one-hot or 000
- sec_left  output  4  whole seconds remaining in current phase
- phase_chg  output  1  one-cycle pulse after every state change

## Operation
- States: NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, FLASH.
- Normal cycle: ALL_RED_2 → NS_GREEN → NS_YELLOW → ALL_RED_1 → EW_GREEN → EW_YELLOW → ALL_RED_2.
- Lights by state:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - ALL_RED_*: NS=100, EW=100.
  - EW_GREEN: NS=100, EW=001.
  - EW_YELLOW: NS=100, EW=010.
  - FLASH: both heads 010 or 000, alternating each tick.
- Prescaler: counter 0..TICK_DIV. tick=1 when count==TICK_DIV, after which the counter wraps to 0. The counter is cleared on every state change, so each phase lasts exactly duration×(TICK_DIV+1) cycles.
- On entry to a phase, sec_left loads that phase's duration. Each tick decrements it. A tick with sec_left==1 ends the phase, and sec_left loads the next phase's duration. sec_left never shows 0 outside FLASH.
- Green hold: in NS_GREEN, a tick with sec_left==1 and no pending request keeps the state; sec_left stays 1.
- Request latch `pend`:
  - Set by ew_req=1 in any state except EW_GREEN.
  - Cleared on the edge entering EW_GREEN; clear wins over a simultaneous set.
- maint=1 forces FLASH on the next edge from any state, and clears the prescaler.
  - In FLASH: sec_left=0, flash phase starts lit (010).
  - When maint falls: FLASH → ALL_RED_2 with sec_left=ALLRED_SEC.
  - pend is kept through FLASH.
- Safety invariant: ns_light and ew_light are never both non-red outside FLASH.

## Timing
- Reset (rst_n=0, asynchronous) values:
  - State ALL_RED_2, sec_left=ALLRED_SEC, prescaler 0, pend 0.
  - ns_light=ew_light=100, phase_chg=0.
- State, lights, sec_left and phase_chg are registered. The new lights are visible right after the edge on which the transition occurs (zero added latency).
- First tick after reset release occurs at the (TICK_DIV+1)-th rising edge.
- phase_chg is high for exactly the cycle following each state-change edge. It stays low for green hold and for reset.
- Simultaneous maint=1 and end-of-phase tick: FLASH wins.
- An ew_req pulse of one cycle is sufficient to be latched.
- Reset mid-phase aborts immediately; no partial-phase memory survives.

## Structure
- Shared package traffic_pkg:
  - State enum.
  - Light encodings LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001, LIGHT_OFF=3'b000.
  - Default duration constants.
- Sub-module tick_gen:
  - Parameter TICK_DIV.
  - Ports clk, rst_n, clr, tick.
  - Counter width $clog2(TICK_DIV+1).
- FSM, pend latch, sec_left counter and output decode live in traffic_light_ctrl.

## Test plan
Common settings for all scenarios: TICK_DIV=3, GREEN_SEC=3, YELLOW_SEC=2, ALLRED_SEC=1.

- Reset release with ew_req held 1:
  - All-red for 4 cycles.
  - Then NS green 12 cycles (sec_left 3,2,1), NS yellow 8, all-red 4, EW green 12, EW yellow 8, all-red 4.
  - Full cycle 48 cycles; phase_chg pulses 6 times per cycle.
- ew_req held 0:
  - NS green persists indefinitely with sec_left=1 and no phase_chg.
  - A single-cycle ew_req pulse at cycle 40 gives NS yellow at the next tick edge (cycle 44).
- ew_req pulsed during EW_GREEN only: ignored; the next NS green holds.
- ew_req asserted on the same edge ALL_RED_1→EW_GREEN: pend ends 0.
- maint asserted mid NS_YELLOW:
  - FLASH on the next edge; both heads toggle 010/000 every 4 cycles.
  - maint deasserted: all-red 4 cycles, then NS green.
- rst_n dropped mid EW_GREEN: outputs immediately 100/100 and sec_left=1 without a clock edge; sequencing restarts as in the first scenario.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection sequencer: state encoding, lamp patterns, default timings.
// Lamp patterns are {red, yellow, green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    localparam int DEF_TICK_DIV   = 60;
    localparam int DEF_GREEN_SEC  = 9;
    localparam int DEF_YELLOW_SEC = 2;
    localparam int DEF_ALLRED_SEC = 1;

    // Returns {ns_light, ew_light} for a state; flash_on only matters in FLASH.
    function automatic logic [5:0] decode_lights(input state_t s, input logic flash_on);
        logic [5:0] l;
        l = {LIGHT_RED, LIGHT_RED};
        case (s)
            NS_GREEN:  l = {LIGHT_GRN, LIGHT_RED};
            NS_YELLOW: l = {LIGHT_YEL, LIGHT_RED};
            EW_GREEN:  l = {LIGHT_RED, LIGHT_GRN};
            EW_YELLOW: l = {LIGHT_RED, LIGHT_YEL};
            FLASH:     l = flash_on ? {LIGHT_YEL, LIGHT_YEL} : {LIGHT_OFF, LIGHT_OFF};
            default:   l = {LIGHT_RED, LIGHT_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: tick is high for one clk when the count reaches TICK_DIV, then wraps.
// Combinational tick from the registered count; clr restarts the second on the next edge.
module tick_gen #(
    parameter int TICK_DIV = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer with NS green hold, EW request latch and maintenance flash.
// Lights/sec_left/phase_chg registered from next state (visible right after the transition edge); no backpressure.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int GREEN_SEC  = DEF_GREEN_SEC,
    parameter int YELLOW_SEC = DEF_YELLOW_SEC,
    parameter int ALLRED_SEC = DEF_ALLRED_SEC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ew_req,
    input  logic       maint,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] sec_left,
    output logic       phase_chg
);

    state_t     state;
    state_t     state_nx;
    logic [3:0] sec_nx;
    logic       flash_on;
    logic       flash_nx;
    logic       pend;
    logic       pend_nx;
    logic       tick;
    logic       chg;

    function automatic logic [3:0] dur_of(input state_t s);
        logic [3:0] d;
        case (s)
            NS_GREEN, EW_GREEN:   d = 4'(GREEN_SEC);
            NS_YELLOW, EW_YELLOW: d = 4'(YELLOW_SEC);
            FLASH:                d = 4'd0;
            default:              d = 4'(ALLRED_SEC);
        endcase
        return d;
    endfunction

    assign chg = (state_nx != state);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (chg),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        sec_nx   = sec_left;
        flash_nx = flash_on;
        if (maint) begin
            state_nx = FLASH;
            sec_nx   = 4'd0;
            if (state != FLASH) begin
                flash_nx = 1'b1;
            end else if (tick) begin
                flash_nx = ~flash_on;
            end
        end else if (state == FLASH) begin
            state_nx = ALL_RED_2;
            sec_nx   = 4'(ALLRED_SEC);
        end else if (tick) begin
            if (sec_left == 4'd1) begin
                case (state)
                    NS_GREEN:  state_nx = pend ? NS_YELLOW : NS_GREEN;
                    NS_YELLOW: state_nx = ALL_RED_1;
                    ALL_RED_1: state_nx = EW_GREEN;
                    EW_GREEN:  state_nx = EW_YELLOW;
                    EW_YELLOW: state_nx = ALL_RED_2;
                    default:   state_nx = NS_GREEN;
                endcase
                // Green hold leaves sec_left parked at 1.
                if (state_nx != state) begin
                    sec_nx = dur_of(state_nx);
                end
            end else begin
                sec_nx = sec_left - 4'd1;
            end
        end
    end

    always_comb begin
        pend_nx = pend;
        if (ew_req && state != EW_GREEN) begin
            pend_nx = 1'b1;
        end
        if (state_nx == EW_GREEN && state != EW_GREEN) begin
            pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALL_RED_2;
            sec_left  <= 4'(ALLRED_SEC);
            flash_on  <= 1'b0;
            pend      <= 1'b0;
            ns_light  <= LIGHT_RED;
            ew_light  <= LIGHT_RED;
            phase_chg <= 1'b0;
        end else begin
            state                <= state_nx;
            sec_left             <= sec_nx;
            flash_on             <= flash_nx;
            pend                 <= pend_nx;
            {ns_light, ew_light} <= decode_lights(state_nx, flash_nx);
            phase_chg            <= chg;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

    localparam int TD  = 3;
    localparam int PER = TD + 1;

    logic       clk;
    logic       rst_n;
    logic       ew_req;
    logic       maint;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] sec_left;
    logic       phase_chg;

    int vectors;
    int miscompares;

    traffic_light_ctrl #(
        .TICK_DIV  (TD),
        .GREEN_SEC (3),
        .YELLOW_SEC(2),
        .ALLRED_SEC(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ew_req   (ew_req),
        .maint    (maint),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .sec_left (sec_left),
        .phase_chg(phase_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: phase index into a table plus elapsed cycles in the phase.
    int         dur    [6] = '{3, 2, 1, 3, 2, 1};
    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int m_ph, m_cyc, m_fcyc;
    bit m_flash, m_pend, m_chg;

    task automatic model_reset();
        m_ph = 5; m_cyc = 0; m_fcyc = 0;
        m_flash = 0; m_pend = 0; m_chg = 0;
    endtask

    task automatic model_step();
        bit set_ok;
        bit old_pend;
        set_ok   = ew_req && !(!m_flash && m_ph == 3);
        old_pend = m_pend;
        m_chg    = 0;
        if (maint) begin
            if (!m_flash) begin
                m_flash = 1; m_fcyc = 0; m_chg = 1;
            end else begin
                m_fcyc++;
            end
        end else if (m_flash) begin
            m_flash = 0; m_ph = 5; m_cyc = 0; m_chg = 1;
        end else begin
            m_cyc++;
            if (m_cyc == dur[m_ph] * PER) begin
                if (m_ph == 0 && !old_pend) begin
                    m_cyc -= PER;
                end else begin
                    m_ph = (m_ph + 1) % 6; m_cyc = 0; m_chg = 1;
                end
            end
        end
        if (set_ok) m_pend = 1;
        if (m_chg && !m_flash && m_ph == 3) m_pend = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] e_ns, e_ew;
        logic [3:0] e_sec;
        if (m_flash) begin
            e_ns  = ((m_fcyc / PER) % 2 == 0) ? 3'b010 : 3'b000;
            e_ew  = e_ns;
            e_sec = 4'd0;
        end else begin
            e_ns  = ns_tab[m_ph];
            e_ew  = ew_tab[m_ph];
            e_sec = 4'(dur[m_ph] - m_cyc / PER);
        end
        chk("ns_light", {5'd0, ns_light}, {5'd0, e_ns});
        chk("ew_light", {5'd0, ew_light}, {5'd0, e_ew});
        chk("sec_left", {4'd0, sec_left}, {4'd0, e_sec});
        chk("phase_chg", {7'd0, phase_chg}, {7'd0, m_chg});
        if (!m_flash) begin
            chk("safety", {7'd0, (ns_light == 3'b100 || ew_light == 3'b100)}, 8'd1);
        end
    endtask

    // Inputs are already stable; advance one edge and check at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int  n;
        bit  found;
        vectors     = 0;
        miscompares = 0;
        ew_req      = 1'b0;
        maint       = 1'b0;
        rst_n       = 1'b1;
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        rst_n  = 1'b1;
        ew_req = 1'b1;

        // ew_req held high: full 48-cycle sequence with six phase changes
        n = 0;
        for (int i = 1; i <= 52; i++) begin
            cycle();
            if (i >= 4 && i <= 51 && phase_chg) n++;
        end
        chk("chg_per_cycle", 8'(n), 8'd6);

        // ew_req low: NS green holds, then a single-cycle request releases it
        ew_req = 1'b0;
        run(100);
        chk("hold_ns", {5'd0, ns_light}, 8'h01);
        chk("hold_sec", {4'd0, sec_left}, 8'd1);
        ew_req = 1'b1;
        cycle();
        ew_req = 1'b0;
        run(30);

        // Random sparse requests
        for (int i = 0; i < 300; i++) begin
            ew_req = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // Requests only during EW green are ignored
        for (int i = 0; i < 150; i++) begin
            ew_req = (!m_flash && m_ph == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycle();
        end

        // Request coinciding with ALL_RED_1 -> EW_GREEN edge is cleared
        ew_req = 1'b1;
        cycle();
        ew_req = 1'b0;
        found  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!m_flash && m_ph == 2 && m_cyc == PER - 1) found = 1;
            else cycle();
        end
        chk("reach_ar1_end", {7'd0, found}, 8'd1);
        ew_req = 1'b1;
        cycle();
        ew_req = 1'b0;
        run(60);

        // Maintenance mid NS yellow
        ew_req = 1'b1;
        found  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!m_flash && m_ph == 1 && m_cyc == 2) found = 1;
            else cycle();
        end
        chk("reach_ns_yel", {7'd0, found}, 8'd1);
        maint = 1'b1;
        run(20);
        maint = 1'b0;
        run(30);

        // Random maintenance toggles and requests
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 30) == 0) maint = ~maint;
            ew_req = ($urandom_range(0, 7) == 0);
            cycle();
        end
        maint = 1'b0;
        run(10);

        // Reset mid EW green
        ew_req = 1'b1;
        found  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!m_flash && m_ph == 3 && m_cyc == 5) found = 1;
            else cycle();
        end
        chk("reach_ew_grn", {7'd0, found}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
